// File: rtl/sp_base_pkg.sv
// Base scalar types shared across the scratchpad / matrix unit.
//   word_t       : 32-bit machine word
//   matbits_t    : matrix register index
//   matrix_mem_t : matrix memory operation selector (load or store)
package sp_base_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  matbits_t;

  typedef enum logic {
    MatLoad  = 1'b0,
    MatStore = 1'b1
  } matrix_mem_t;

endpackage

// File: rtl/sp_types_pkg.sv
// Types for the matrix load/store sequencer.
//   mls_row_req_t : one row request sent to the scratchpad
//   mls_entry_t   : one queued matrix load/store instruction
//   mls_state_e   : sequencer FSM state
package sp_types_pkg;
  import sp_base_pkg::*;

  // Row index field is sized for up to 256 rows per instruction.
  localparam int unsigned ROW_IDX_W = 8;

  typedef struct packed {
    matrix_mem_t          ls;
    matbits_t             rd;
    logic [ROW_IDX_W-1:0] row;
    word_t                addr;
  } mls_row_req_t;

  typedef struct packed {
    matrix_mem_t ls;
    matbits_t    rd;
    word_t       base;
    word_t       stride;
  } mls_entry_t;

  typedef enum logic {
    MlsIdle,
    MlsIssue
  } mls_state_e;

endpackage

// File: rtl/mls_fifo.sv
// Instruction queue for the matrix load/store sequencer.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write one entry at the tail (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head, head_next  : entry at the head and the one behind it
//   full, empty      : derived from registered occupancy only
//   count            : registered occupancy
module mls_fifo
  import sp_types_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = mls_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output entry_t                 head_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head       = mem[rd_ptr_q];
  assign head_next  = mem[rd_ptr_nxt];

  // Storage is not reset; consumers qualify the head with occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fu_matrix_ls_seq.sv
// Matrix load/store sequencer: queues matrix load/store instructions and
// expands each into ROWS row requests to the scratchpad.
// Build option: define MLS_STRIDE_EN to add the stride_in port and capture
// a per-instruction stride; otherwise every instruction uses ROW_STRIDE.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   enable                : dispatch strobe; accept = enable && !full
//   ls_in, rd_in          : operation and matrix register
//   rs_in, imm_in         : base = rs_in + imm_in
//   stride_in             : per-instruction row stride (MLS_STRIDE_EN only)
//   accept, full          : dispatch taken / queue full
//   req_valid, req_ready  : row request handshake
//   req_out               : {ls, rd, row, address}
//   done, done_rd         : one-cycle completion pulse and its register
module fu_matrix_ls_seq
  import sp_base_pkg::*;
  import sp_types_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ROWS       = 4,
  parameter logic [31:0] ROW_STRIDE = 32'd16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enable,
  input  matrix_mem_t  ls_in,
  input  matbits_t     rd_in,
  input  word_t        rs_in,
  input  word_t        imm_in,
`ifdef MLS_STRIDE_EN
  input  word_t        stride_in,
`endif
  output logic         accept,
  output logic         full,
  output logic         req_valid,
  input  logic         req_ready,
  output mls_row_req_t req_out,
  output logic         done,
  output matbits_t     done_rd
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  mls_state_e       state_q;
  logic [ROW_W-1:0] row_q;
  word_t            addr_q;
  logic             done_q;
  matbits_t         done_rd_q;

  mls_entry_t       push_entry;
  mls_entry_t       head;
  mls_entry_t       head_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic             handshake;
  logic             last_row;
  logic             pop;
  logic             more_after_pop;
  word_t            next_base;
  word_t            start_base;

  always_comb begin
    push_entry      = '0;
    push_entry.ls   = ls_in;
    push_entry.rd   = rd_in;
    push_entry.base = rs_in + imm_in;
`ifdef MLS_STRIDE_EN
    push_entry.stride = stride_in;
`else
    push_entry.stride = ROW_STRIDE;
`endif
  end

  assign accept = enable && !fifo_full;
  assign full   = fifo_full;

  mls_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (mls_entry_t)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign handshake = (state_q == MlsIssue) && req_ready;
  assign last_row  = (row_q == ROW_W'(ROWS - 1));
  assign pop       = handshake && last_row;

  // Pick the instruction that follows the head without a bubble: the entry
  // behind the head if one exists, else whatever is being pushed right now.
  always_comb begin
    more_after_pop = (fifo_count > CNT_W'(1)) || accept;
    next_base      = (fifo_count > CNT_W'(1)) ? head_next.base : push_entry.base;
    start_base     = fifo_empty ? push_entry.base : head.base;
  end

  // Only the base of the following entry is consumed here.
  logic unused_head_next;
  assign unused_head_next = ^{head_next.ls, head_next.rd, head_next.stride};
`ifdef MLS_STRIDE_EN
  logic unused_row_stride;
  assign unused_row_stride = ^ROW_STRIDE;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= MlsIdle;
      row_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      done_rd_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MlsIdle: begin
          // A push into the empty queue starts issuing on the next cycle.
          if (!fifo_empty || accept) begin
            state_q <= MlsIssue;
            row_q   <= '0;
            addr_q  <= start_base;
          end
        end
        MlsIssue: begin
          if (handshake) begin
            if (last_row) begin
              done_q    <= 1'b1;
              done_rd_q <= head.rd;
              row_q     <= '0;
              if (more_after_pop) begin
                addr_q <= next_base;
              end else begin
                state_q <= MlsIdle;
                addr_q  <= '0;
              end
            end else begin
              row_q  <= row_q + ROW_W'(1);
              addr_q <= addr_q + head.stride;
            end
          end
        end
        default: state_q <= MlsIdle;
      endcase
    end
  end

  assign req_valid = (state_q == MlsIssue);
  assign done      = done_q;
  assign done_rd   = done_rd_q;

  // Head fields are qualified by state so idle/reset outputs read as zero.
  always_comb begin
    req_out = '0;
    if (state_q == MlsIssue) begin
      req_out.ls   = head.ls;
      req_out.rd   = head.rd;
      req_out.row  = ROW_IDX_W'(row_q);
      req_out.addr = addr_q;
    end
  end

endmodule
